// File: rtl/multicycle_dbg_pkg.sv
// Shared types and constants for the multicycle run-control / debug unit.
package multicycle_dbg_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } run_state_e;

  localparam logic [1:0] HALT_NONE = 2'd0;
  localparam logic [1:0] HALT_REQ  = 2'd1;
  localparam logic [1:0] HALT_BP   = 2'd2;
  localparam logic [1:0] HALT_STEP = 2'd3;

  // Breakpoint index width; a single slot still needs a 1-bit index.
  function automatic int unsigned bp_idx_w(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/multicycle_run_control_if.sv
// Debug-host / core-observation bundle for multicycle_run_control.
interface multicycle_run_control_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned STATE_W  = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned BP_IDX_W = 1
);
  logic [STATE_W-1:0]  core_state;
  logic [ADDR_W-1:0]   core_pc;
  logic                dbg_halt_req;
  logic                dbg_run_req;
  logic                dbg_step_req;
  logic                bp_wr_en;
  logic [BP_IDX_W-1:0] bp_wr_idx;
  logic [ADDR_W-1:0]   bp_wr_addr;
  logic                bp_wr_valid;
  logic                cnt_clr;
  logic                core_en;
  logic                halted;
  logic [1:0]          run_state;
  logic [1:0]          halt_cause;
  logic [CNT_W-1:0]    cycle_count;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output core_state, core_pc, dbg_halt_req, dbg_run_req, dbg_step_req,
           bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid, cnt_clr,
    input  core_en, halted, run_state, halt_cause, cycle_count, instr_count
  );

  modport slave (
    input  core_state, core_pc, dbg_halt_req, dbg_run_req, dbg_step_req,
           bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid, cnt_clr,
    output core_en, halted, run_state, halt_cause, cycle_count, instr_count
  );
endinterface

// File: rtl/mc_bp_match.sv
// PC breakpoint register file with an OR-reduced match against the current PC.
module mc_bp_match
  import multicycle_dbg_pkg::*;
#(
  parameter int unsigned NUM_BP = 2,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned IDX_W = bp_idx_w(NUM_BP)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_c_o
);

  logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_valid_q;

  // Out-of-range indices match no slot and are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bp_valid_q <= '0;
      for (int unsigned i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < NUM_BP; i++) begin
        if (32'(wr_idx_i) == i) begin
          bp_addr_q[i]  <= wr_addr_i;
          bp_valid_q[i] <= wr_valid_i;
        end
      end
    end
  end

  always_comb begin
    hit_c_o = 1'b0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == pc_i)) hit_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_run_control.sv
// Run/halt/step control, breakpoint halting and cycle/instruction counters
// for the multicycle core; core_en is combinational so a halt costs no extra cycle.
module multicycle_run_control
  import multicycle_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_BP       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned STATE_W      = 4,
  parameter int unsigned FETCH_STATE  = 0,
  parameter int unsigned START_HALTED = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  multicycle_run_control_if.slave dbg
);

  localparam run_state_e RESET_STATE = (START_HALTED != 0) ? HALTED : RUN;

  run_state_e       state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic             halt_pend_q, halt_pend_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             boundary_c, bp_hit_c, stop_c, core_en_c;

  mc_bp_match #(
    .NUM_BP (NUM_BP),
    .ADDR_W (ADDR_W)
  ) u_bp_match (
    .clk_i      (clock_i),
    .rst_i      (reset_i),
    .wr_en_i    (dbg.bp_wr_en),
    .wr_idx_i   (dbg.bp_wr_idx),
    .wr_addr_i  (dbg.bp_wr_addr),
    .wr_valid_i (dbg.bp_wr_valid),
    .pc_i       (dbg.core_pc),
    .hit_c_o    (bp_hit_c)
  );

  assign boundary_c = (dbg.core_state == STATE_W'(FETCH_STATE));
  assign stop_c     = halt_pend_q | (armed_q & bp_hit_c);

  // Run-control FSM; armed stays low until the resumed instruction leaves fetch.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    halt_pend_d = halt_pend_q;
    armed_d     = armed_q;
    core_en_c   = 1'b0;
    case (state_q)
      RUN: begin
        core_en_c = !(boundary_c && stop_c);
        if (dbg.dbg_halt_req) halt_pend_d = 1'b1;
        if (boundary_c && stop_c) begin
          state_d     = HALTED;
          halt_pend_d = 1'b0;
          cause_d     = (armed_q && bp_hit_c) ? HALT_BP : HALT_REQ;
        end
      end
      HALTED: begin
        if (dbg.dbg_step_req) begin
          state_d = STEP;
          armed_d = 1'b0;
        end else if (dbg.dbg_run_req) begin
          state_d = RUN;
          armed_d = 1'b0;
        end
      end
      STEP: begin
        core_en_c = !(boundary_c && armed_q);
        if (boundary_c && armed_q) begin
          state_d = HALTED;
          cause_d = HALT_STEP;
        end
      end
      default: state_d = RUN;
    endcase
    if (core_en_c && !boundary_c) armed_d = 1'b1;
  end

  // Counters; a clear overrides a same-cycle increment.
  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (dbg.cnt_clr) begin
      cycle_d = '0;
      instr_d = '0;
    end else if (core_en_c) begin
      cycle_d = cycle_q + CNT_W'(1);
      if (boundary_c) instr_d = instr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= RESET_STATE;
      cause_q     <= HALT_NONE;
      halt_pend_q <= 1'b0;
      armed_q     <= 1'b0;
      cycle_q     <= '0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      halt_pend_q <= halt_pend_d;
      armed_q     <= armed_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
    end
  end

  assign dbg.core_en     = core_en_c;
  assign dbg.halted      = (state_q == HALTED);
  assign dbg.run_state   = state_q;
  assign dbg.halt_cause  = cause_q;
  assign dbg.cycle_count = cycle_q;
  assign dbg.instr_count = instr_q;

endmodule

// File: tb/tb_multicycle_run_control.sv
// Directed bench for multicycle_run_control driving 4-state stub cores (pc += 4 per instruction).
`timescale 1ns/1ps
module tb_multicycle_run_control;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  multicycle_run_control_if #(.ADDR_W(32), .STATE_W(4), .CNT_W(32), .BP_IDX_W(1)) ifa ();
  multicycle_run_control_if #(.ADDR_W(32), .STATE_W(4), .CNT_W(4),  .BP_IDX_W(2)) ifb ();

  multicycle_run_control #(
    .ADDR_W(32), .NUM_BP(2), .CNT_W(32), .STATE_W(4), .FETCH_STATE(0), .START_HALTED(0)
  ) dut_a (
    .clock_i (clk),
    .reset_i (rst),
    .dbg     (ifa)
  );

  multicycle_run_control #(
    .ADDR_W(32), .NUM_BP(3), .CNT_W(4), .STATE_W(4), .FETCH_STATE(0), .START_HALTED(1)
  ) dut_b (
    .clock_i (clk),
    .reset_i (rst),
    .dbg     (ifb)
  );

  // Stub cores: states 0..3, pc advances after state 3.
  logic [1:0]  st_a, st_b;
  logic [31:0] pc_a, pc_b;

  always @(posedge clk) begin
    if (rst) begin
      st_a <= 2'd0;
      pc_a <= 32'd0;
    end else if (ifa.core_en) begin
      st_a <= st_a + 2'd1;
      if (st_a == 2'd3) pc_a <= pc_a + 32'd4;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      st_b <= 2'd0;
      pc_b <= 32'd0;
    end else if (ifb.core_en) begin
      st_b <= st_b + 2'd1;
      if (st_b == 2'd3) pc_b <= pc_b + 32'd4;
    end
  end

  assign ifa.core_state = {2'b00, st_a};
  assign ifa.core_pc    = pc_a;
  assign ifb.core_state = {2'b00, st_b};
  assign ifb.core_pc    = pc_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel: 0 = halt, 1 = run, 2 = step
  task automatic pulse_a(input int sel);
    ifa.dbg_halt_req = (sel == 0);
    ifa.dbg_run_req  = (sel == 1);
    ifa.dbg_step_req = (sel == 2);
    tick(1);
    ifa.dbg_halt_req = 1'b0;
    ifa.dbg_run_req  = 1'b0;
    ifa.dbg_step_req = 1'b0;
  endtask

  task automatic wait_halt_a(input string tag);
    int k;
    k = 0;
    while (ifa.halted !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
    check_eq({tag, "_halted"}, 64'(ifa.halted), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cyc;
    int k;
    rst = 1'b1;
    ifa.dbg_halt_req = 1'b0; ifa.dbg_run_req = 1'b0; ifa.dbg_step_req = 1'b0;
    ifa.bp_wr_en = 1'b0; ifa.bp_wr_idx = '0; ifa.bp_wr_addr = '0; ifa.bp_wr_valid = 1'b0;
    ifa.cnt_clr = 1'b0;
    ifb.dbg_halt_req = 1'b0; ifb.dbg_run_req = 1'b0; ifb.dbg_step_req = 1'b0;
    ifb.bp_wr_en = 1'b0; ifb.bp_wr_idx = '0; ifb.bp_wr_addr = '0; ifb.bp_wr_valid = 1'b0;
    ifb.cnt_clr = 1'b0;
    tick(2);

    // Reset values for both configurations
    check_eq("rst_run_state", 64'(ifa.run_state), 64'd0);
    check_eq("rst_halted", 64'(ifa.halted), 64'd0);
    check_eq("rst_cause", 64'(ifa.halt_cause), 64'd0);
    check_eq("rst_cycle", 64'(ifa.cycle_count), 64'd0);
    check_eq("rst_instr", 64'(ifa.instr_count), 64'd0);
    check_eq("rst_core_en", 64'(ifa.core_en), 64'd1);
    check_eq("b_rst_halted", 64'(ifb.halted), 64'd1);
    check_eq("b_rst_run_state", 64'(ifb.run_state), 64'd1);
    check_eq("b_rst_core_en", 64'(ifb.core_en), 64'd0);

    // Free run for 40 cycles
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check_eq($sformatf("run_core_en_%0d", i), 64'(ifa.core_en), 64'd1);
      tick(1);
    end
    check_eq("run_cycle", 64'(ifa.cycle_count), 64'd40);
    check_eq("run_instr", 64'(ifa.instr_count), 64'd10);

    // Breakpoint slot 1 at 0x10
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    ifa.bp_wr_en = 1'b1; ifa.bp_wr_idx = 1'b1; ifa.bp_wr_addr = 32'h10; ifa.bp_wr_valid = 1'b1;
    tick(1);
    ifa.bp_wr_en = 1'b0;
    wait_halt_a("bp");
    check_eq("bp_pc", 64'(ifa.core_pc), 64'h10);
    check_eq("bp_state", 64'(ifa.core_state), 64'd0);
    check_eq("bp_cause", 64'(ifa.halt_cause), 64'd2);
    check_eq("bp_instr", 64'(ifa.instr_count), 64'd4);
    check_eq("bp_cycle", 64'(ifa.cycle_count), 64'd16);
    check_eq("bp_core_en", 64'(ifa.core_en), 64'd0);
    check_eq("bp_run_state", 64'(ifa.run_state), 64'd1);

    // Three single steps from 0x10
    for (int s = 1; s <= 3; s++) begin
      en_cyc = 0;
      k = 0;
      pulse_a(2);
      while (ifa.halted !== 1'b1 && k < 40) begin
        if (ifa.core_en === 1'b1) en_cyc++;
        tick(1);
        k++;
      end
      check_eq($sformatf("step%0d_halted", s), 64'(ifa.halted), 64'd1);
      check_eq($sformatf("step%0d_en_cycles", s), 64'(en_cyc), 64'd4);
      check_eq($sformatf("step%0d_pc", s), 64'(ifa.core_pc), 64'(32'h10 + 32'(4 * s)));
      check_eq($sformatf("step%0d_cause", s), 64'(ifa.halt_cause), 64'd3);
    end

    // Halt request while HALTED is dropped, then run and halt mid-instruction at 0x20
    pulse_a(0);
    check_eq("halted_ignores_halt", 64'(ifa.halted), 64'd1);
    pulse_a(1);
    check_eq("run_latency_core_en", 64'(ifa.core_en), 64'd1);
    check_eq("run_latency_state", 64'(ifa.run_state), 64'd0);
    tick(6);
    check_eq("pre_req_pc", 64'(ifa.core_pc), 64'h20);
    check_eq("pre_req_state", 64'(ifa.core_state), 64'd2);
    check_eq("pre_req_halted", 64'(ifa.halted), 64'd0);
    pulse_a(0);
    wait_halt_a("req");
    check_eq("req_pc", 64'(ifa.core_pc), 64'h24);
    check_eq("req_cause", 64'(ifa.halt_cause), 64'd1);
    check_eq("req_state", 64'(ifa.core_state), 64'd0);

    // Halt request in a boundary cycle stops at the next boundary
    pulse_a(1);
    check_eq("bnd_pre_pc", 64'(ifa.core_pc), 64'h24);
    pulse_a(0);
    wait_halt_a("bnd");
    check_eq("bnd_pc", 64'(ifa.core_pc), 64'h28);
    check_eq("bnd_cause", 64'(ifa.halt_cause), 64'd1);

    // Breakpoint written while halted, then resume past it
    ifa.bp_wr_en = 1'b1; ifa.bp_wr_idx = 1'b0; ifa.bp_wr_addr = 32'h30; ifa.bp_wr_valid = 1'b1;
    tick(1);
    ifa.bp_wr_en = 1'b0;
    pulse_a(1);
    wait_halt_a("bp2");
    check_eq("bp2_pc", 64'(ifa.core_pc), 64'h30);
    check_eq("bp2_cause", 64'(ifa.halt_cause), 64'd2);
    pulse_a(1);
    check_eq("resume_bp_core_en", 64'(ifa.core_en), 64'd1);
    tick(12);
    check_eq("resume_bp_halted", 64'(ifa.halted), 64'd0);
    check_eq("resume_bp_pc", 64'(ifa.core_pc), 64'h3C);

    // Counter clear beats a same-cycle increment
    ifa.cnt_clr = 1'b1;
    tick(1);
    ifa.cnt_clr = 1'b0;
    check_eq("clr_cycle", 64'(ifa.cycle_count), 64'd0);
    check_eq("clr_instr", 64'(ifa.instr_count), 64'd0);
    tick(4);
    check_eq("post_clr_cycle", 64'(ifa.cycle_count), 64'd4);
    check_eq("post_clr_instr", 64'(ifa.instr_count), 64'd1);

    // Reset during STEP returns to RUN and clears breakpoints
    pulse_a(0);
    wait_halt_a("pre_step_rst");
    pulse_a(2);
    check_eq("in_step_state", 64'(ifa.run_state), 64'd2);
    rst = 1'b1;
    tick(1);
    check_eq("step_rst_state", 64'(ifa.run_state), 64'd0);
    check_eq("step_rst_halted", 64'(ifa.halted), 64'd0);
    check_eq("step_rst_cause", 64'(ifa.halt_cause), 64'd0);
    check_eq("step_rst_cycle", 64'(ifa.cycle_count), 64'd0);
    rst = 1'b0;
    tick(60);
    check_eq("bp_cleared_halted", 64'(ifa.halted), 64'd0);
    check_eq("bp_cleared_pc", 64'(ifa.core_pc), 64'h3C);

    // CNT_W=4 wrap; out-of-range breakpoint index is ignored
    check_eq("b_halted_cycle", 64'(ifb.cycle_count), 64'd0);
    ifb.bp_wr_en = 1'b1; ifb.bp_wr_idx = 2'd3; ifb.bp_wr_addr = 32'h8; ifb.bp_wr_valid = 1'b1;
    tick(1);
    ifb.bp_wr_en = 1'b0;
    ifb.dbg_run_req = 1'b1;
    tick(1);
    ifb.dbg_run_req = 1'b0;
    tick(20);
    check_eq("b_wrap_cycle", 64'(ifb.cycle_count), 64'd4);
    check_eq("b_wrap_instr", 64'(ifb.instr_count), 64'd5);
    check_eq("b_idx_oob_halted", 64'(ifb.halted), 64'd0);
    check_eq("b_pc", 64'(ifb.core_pc), 64'h14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_run_control.md
# multicycle_run_control

Parametrised run-control and debug unit for the multicycle computer: generates a clock-enable for the core, halts it cleanly at instruction boundaries on request or on a PC breakpoint, single-steps one instruction at a time, and keeps cycle and retired-instruction counters. It sits between the top-level computer and the bench/debug host. It is the successor to the fixed R0/R1/state observation ports, which expose the core but cannot control it.

## Interface
- ADDR_W, 32: width of the core PC.
- NUM_BP, 2: number of PC breakpoint comparators, minimum 1.
- CNT_W, 32: width of the cycle and instruction counters.
- STATE_W, 4: width of the controller state code.
- FETCH_STATE, 0: controller state code of the fetch state.
- START_HALTED, 0: 1 means the unit leaves reset in HALTED.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- core_state  in  STATE_W  current controller state of the core.
- core_pc  in  ADDR_W  current PC of the core.
- dbg_halt_req  in  1  one-cycle pulse requesting a halt.
- dbg_run_req  in  1  one-cycle pulse requesting resume from HALTED.
- dbg_step_req  in  1  one-cycle pulse requesting a single step from HALTED.
- bp_wr_en  in  1  breakpoint register write strobe.
- bp_wr_idx  in  max(1,clog2(NUM_BP))  breakpoint slot to write.
- bp_wr_addr  in  ADDR_W  breakpoint PC value.
- bp_wr_valid  in  1  enable bit written to the slot.
- cnt_clr  in  1  synchronous clear of both counters.
- core_en  out  1  clock-enable for every core state element (PC, IR, registers, flags, controller state).
- halted  out  1  high while the FSM is in HALTED.
- run_state  out  2  FSM state encoding.
- halt_cause  out  2  reason for the last halt.
- cycle_count  out  CNT_W  number of cycles with core_en=1.
- instr_count  out  CNT_W  number of fetches executed.

## Operation
- A boundary cycle is any cycle with core_state==FETCH_STATE. When core_en=0 in a boundary cycle, the core is frozen before it fetches the instruction at core_pc.
- FSM states:
  - RUN: core_en = !(boundary & stop), where stop = halt_pend | (armed & bp_hit).
    - If boundary & stop: go to HALTED, clear halt_pend, set halt_cause (BP=2 has priority over REQ=1).
  - HALTED: core_en=0.
    - dbg_step_req: go to STEP.
    - else dbg_run_req: go to RUN.
    - dbg_step_req has priority over dbg_run_req.
    - dbg_halt_req is ignored.
  - STEP: core_en = !(boundary & armed).
    - If boundary & armed: go to HALTED with halt_cause=STEP (3).
    - Breakpoints and halt requests are ignored in STEP.
- armed:
  - Cleared on reset and on every exit from HALTED.
  - Set in any cycle where core_en=1 and core_state!=FETCH_STATE.
  - Effect: the instruction at the halt PC always executes on resume, so the same breakpoint does not re-fire immediately.
- halt_pend:
  - Set by dbg_halt_req while in RUN; ignored in other states.
  - Registered, so it is honoured at the first boundary cycle at or after t+1, where t is the request cycle.
- bp_hit: any slot i with bp_valid[i] & (bp_addr[i]==core_pc).
- Breakpoint writes:
  - bp_wr_en writes bp_addr/bp_valid for slot bp_wr_idx, effective from the next cycle.
  - An index >= NUM_BP is ignored.
  - Writes are legal in any FSM state.
- Counters:
  - cycle_count increments when core_en=1.
  - instr_count increments when core_en=1 & boundary.
  - Both wrap modulo 2^CNT_W.
  - cnt_clr wins over a same-cycle increment (result 0).

## Timing
- Reset values:
  - run_state = RUN, or HALTED if START_HALTED=1.
  - halted follows run_state.
  - halt_cause=0, counters=0, halt_pend=0, armed=0, all bp_valid=0.
- core_en after reset is 1 in RUN and 0 in HALTED.
- Reset mid-operation, in any state: all values return to the reset values above on the next edge.
- core_en is combinational from registered FSM state plus core_state/core_pc. There is no register on this path, so halting costs zero extra core cycles.
- Latency:
  - Run/step request to core_en=1: 1 cycle.
  - Halt to halted=1: the edge following the stopping boundary cycle.
- run_state encoding: RUN=0, HALTED=1, STEP=2.

## Structure
- Package multicycle_dbg_pkg holds:
  - the run_state enum (RUN, HALTED, STEP);
  - halt-cause constants NONE=0, REQ=1, BP=2, STEP=3.
- Sub-module mc_bp_match, parametrised by NUM_BP and ADDR_W, holds the breakpoint register file and the OR-reduced comparator output.
- The FSM and counters live in the top of the block.

## Test plan
All scenarios use a stub core: 4-cycle instructions with states 0..3, pc+=4 per instruction, FETCH_STATE=0.
- Reset, free run 40 cycles -> core_en=1 throughout; cycle_count=40, instr_count=10.
- Breakpoint slot 1 set to 0x10 -> core frozen with core_pc=0x10, state 0; halted=1, halt_cause=2, instr_count=4.
- dbg_run_req after the breakpoint halt -> the instruction at 0x10 executes without re-halting; the next halt is at 0x10 only after wrap or rewrite.
- dbg_step_req three times from HALTED at 0x10 -> halts at 0x14, 0x18, 0x1C with halt_cause=3; each step lasts 4 core_en cycles.
- dbg_halt_req pulsed in state 2 of the instruction at 0x20 -> halt at 0x24 with halt_cause=1. A pulse in a boundary cycle of pc 0x20 -> halt at 0x24, not 0x20.
- Edge cases:
  - CNT_W=4 run for 20 cycles -> cycle_count=4 (wrapped).
  - cnt_clr together with an increment -> 0.
  - reset asserted during STEP -> run_state=RUN, breakpoints cleared.
